// File: rtl/mem_access_stage_if.sv
// EX/MEM -> MEM/WB pipeline bundle for the memory access stage.
// The pipeline side drives p3_* and observes stall and p4_*; the stage takes the slave view.
interface mem_access_stage_if #(
   parameter int REG_W = 3
);
   logic             p3_valid;
   logic [REG_W-1:0] p3_alu_rd;
   logic [REG_W-1:0] p3_mem_rd;
   logic [31:0]      p3_alu_aluOut;
   logic [31:0]      p3_mem_address;
   logic [31:0]      p3_mem_reg_rd;
   logic             f_memStage_mem_rd_sel;
   logic [31:0]      f_memStage_mem_reg_rd;
   logic             p3_mem_read;
   logic             p3_mem_write;
   logic [1:0]       p3_mem_size;
   logic             p3_mem_signed;
   logic             p3_flag_z;
   logic             p3_flag_n;
   logic             p3_flag_c;
   logic             p3_flag_v;

   logic             stall;
   logic             p4_valid;
   logic [REG_W-1:0] p4_alu_rd;
   logic [REG_W-1:0] p4_mem_rd;
   logic [31:0]      p4_alu_aluOut;
   logic [31:0]      p4_mem_memOut;
   logic             p4_flag_z;
   logic             p4_flag_n;
   logic             p4_flag_c;
   logic             p4_flag_v;
   logic             p4_misalign;

   modport master (
      output p3_valid, p3_alu_rd, p3_mem_rd, p3_alu_aluOut, p3_mem_address,
             p3_mem_reg_rd, f_memStage_mem_rd_sel, f_memStage_mem_reg_rd,
             p3_mem_read, p3_mem_write, p3_mem_size, p3_mem_signed,
             p3_flag_z, p3_flag_n, p3_flag_c, p3_flag_v,
      input  stall, p4_valid, p4_alu_rd, p4_mem_rd, p4_alu_aluOut, p4_mem_memOut,
             p4_flag_z, p4_flag_n, p4_flag_c, p4_flag_v, p4_misalign
   );

   modport slave (
      input  p3_valid, p3_alu_rd, p3_mem_rd, p3_alu_aluOut, p3_mem_address,
             p3_mem_reg_rd, f_memStage_mem_rd_sel, f_memStage_mem_reg_rd,
             p3_mem_read, p3_mem_write, p3_mem_size, p3_mem_signed,
             p3_flag_z, p3_flag_n, p3_flag_c, p3_flag_v,
      output stall, p4_valid, p4_alu_rd, p4_mem_rd, p4_alu_aluOut, p4_mem_memOut,
             p4_flag_z, p4_flag_n, p4_flag_c, p4_flag_v, p4_misalign
   );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: byte-addressed little-endian data memory with a fixed
// multi-cycle access latency, stalling upstream and emitting bubbles until done.
module mem_access_stage #(
   parameter int ADDR_W  = 10,
   parameter int REG_W   = 3,
   parameter int MEM_LAT = 2
) (
   input logic              clk,
   input logic              reset,
   mem_access_stage_if.slave bus
);
   localparam int         DEPTH = 2 ** ADDR_W;
   localparam logic [3:0] LAST  = 4'(MEM_LAT - 1);

   logic [7:0]        mem [DEPTH];
   logic [3:0]        cnt;
   logic              mem_op;
   logic              is_store;
   logic              is_load;
   logic              last_cycle;
   logic              complete;
   logic              misalign;
   logic              do_write;
   logic [ADDR_W-1:0] a0, a1, a2, a3;
   logic [31:0]       store_data;
   logic [31:0]       load_word;
   logic [31:0]       load_val;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^bus.p3_mem_address[31:ADDR_W];

   // A store wins when both request bits are set, so a load is read-only.
   always_comb begin
      mem_op     = bus.p3_valid & (bus.p3_mem_read | bus.p3_mem_write);
      is_store   = bus.p3_mem_write;
      is_load    = bus.p3_mem_read & ~bus.p3_mem_write;
      last_cycle = (cnt == LAST);
      complete   = mem_op & last_cycle;
      a0         = bus.p3_mem_address[ADDR_W-1:0];
      a1         = a0 + ADDR_W'(1);
      a2         = a0 + ADDR_W'(2);
      a3         = a0 + ADDR_W'(3);
      store_data = bus.f_memStage_mem_rd_sel ? bus.f_memStage_mem_reg_rd : bus.p3_mem_reg_rd;
      case (bus.p3_mem_size)
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = a0[0];
         2'b10:   misalign = (a0[1:0] != 2'b00);
         default: misalign = 1'b1;
      endcase
      do_write   = reset & complete & is_store & ~misalign;
   end

   assign bus.stall = mem_op & ~last_cycle;

   always_comb begin
      load_word = {mem[a3], mem[a2], mem[a1], mem[a0]};
      case (bus.p3_mem_size)
         2'b00:   load_val = bus.p3_mem_signed ? {{24{load_word[7]}}, load_word[7:0]}
                                               : {24'b0, load_word[7:0]};
         2'b01:   load_val = bus.p3_mem_signed ? {{16{load_word[15]}}, load_word[15:0]}
                                               : {16'b0, load_word[15:0]};
         2'b10:   load_val = load_word;
         default: load_val = 32'b0;
      endcase
      if (!is_load || misalign) begin
         load_val = 32'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= 4'd0;
      end else if (mem_op && !last_cycle) begin
         cnt <= cnt + 4'd1;
      end else begin
         cnt <= 4'd0;
      end
   end

   // Memory is never cleared by reset; reset only suppresses the completing write.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[a0] <= store_data[7:0];
         if (bus.p3_mem_size != 2'b00) begin
            mem[a1] <= store_data[15:8];
         end
         if (bus.p3_mem_size == 2'b10) begin
            mem[a2] <= store_data[23:16];
            mem[a3] <= store_data[31:24];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset || bus.stall) begin
         bus.p4_valid      <= 1'b0;
         bus.p4_alu_rd     <= '0;
         bus.p4_mem_rd     <= '0;
         bus.p4_alu_aluOut <= 32'b0;
         bus.p4_mem_memOut <= 32'b0;
         bus.p4_flag_z     <= 1'b0;
         bus.p4_flag_n     <= 1'b0;
         bus.p4_flag_c     <= 1'b0;
         bus.p4_flag_v     <= 1'b0;
         bus.p4_misalign   <= 1'b0;
      end else begin
         bus.p4_valid      <= bus.p3_valid;
         bus.p4_alu_rd     <= bus.p3_alu_rd;
         bus.p4_mem_rd     <= bus.p3_mem_rd;
         bus.p4_alu_aluOut <= bus.p3_alu_aluOut;
         bus.p4_mem_memOut <= mem_op ? load_val : 32'b0;
         bus.p4_flag_z     <= bus.p3_flag_z;
         bus.p4_flag_n     <= bus.p3_flag_n;
         bus.p4_flag_c     <= bus.p3_flag_c;
         bus.p4_flag_v     <= bus.p3_flag_v;
         bus.p4_misalign   <= mem_op & misalign;
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: three instances at latencies 2, 4 and 1
// share one clock; each is driven through its own interface instance.
module tb_mem_access_stage;
   typedef struct packed {
      logic        valid;
      logic        rd;
      logic        wr;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] data;
      logic        sel;
      logic [31:0] fwd;
      logic [2:0]  alu_rd;
      logic [2:0]  mem_rd;
      logic [31:0] alu_out;
      logic [3:0]  flags;
   } stim_t;

   logic             clk = 1'b0;
   logic [2:0]       rst_n;
   stim_t            stim [3];
   logic [2:0]       obs_stall;
   logic [2:0]       obs_valid;
   logic [2:0]       obs_mis;
   logic [2:0][2:0]  obs_alurd;
   logic [2:0][2:0]  obs_memrd;
   logic [2:0][31:0] obs_alu;
   logic [2:0][31:0] obs_mem;
   logic [2:0][3:0]  obs_flags;
   int               passed = 0;
   int               total  = 0;

   always #5 clk = ~clk;

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : gen_u
         localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
         mem_access_stage_if #(.REG_W(3)) bus ();
         mem_access_stage #(.ADDR_W(10), .REG_W(3), .MEM_LAT(LAT)) u_dut (
            .clk   (clk),
            .reset (rst_n[g]),
            .bus   (bus)
         );
         assign bus.p3_valid              = stim[g].valid;
         assign bus.p3_alu_rd             = stim[g].alu_rd;
         assign bus.p3_mem_rd             = stim[g].mem_rd;
         assign bus.p3_alu_aluOut         = stim[g].alu_out;
         assign bus.p3_mem_address        = stim[g].addr;
         assign bus.p3_mem_reg_rd         = stim[g].data;
         assign bus.f_memStage_mem_rd_sel = stim[g].sel;
         assign bus.f_memStage_mem_reg_rd = stim[g].fwd;
         assign bus.p3_mem_read           = stim[g].rd;
         assign bus.p3_mem_write          = stim[g].wr;
         assign bus.p3_mem_size           = stim[g].size;
         assign bus.p3_mem_signed         = stim[g].sgn;
         assign bus.p3_flag_z             = stim[g].flags[3];
         assign bus.p3_flag_n             = stim[g].flags[2];
         assign bus.p3_flag_c             = stim[g].flags[1];
         assign bus.p3_flag_v             = stim[g].flags[0];
         assign obs_stall[g] = bus.stall;
         assign obs_valid[g] = bus.p4_valid;
         assign obs_mis[g]   = bus.p4_misalign;
         assign obs_alurd[g] = bus.p4_alu_rd;
         assign obs_memrd[g] = bus.p4_mem_rd;
         assign obs_alu[g]   = bus.p4_alu_aluOut;
         assign obs_mem[g]   = bus.p4_mem_memOut;
         assign obs_flags[g] = {bus.p4_flag_z, bus.p4_flag_n, bus.p4_flag_c, bus.p4_flag_v};
      end
   endgenerate

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) passed++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input int u, input bit rd, input bit wr, input bit [1:0] sz,
                                input bit sg, input logic [31:0] addr, input logic [31:0] data);
      stim[u]        = '0;
      stim[u].valid  = 1'b1;
      stim[u].rd     = rd;
      stim[u].wr     = wr;
      stim[u].size   = sz;
      stim[u].sgn    = sg;
      stim[u].addr   = addr;
      stim[u].data   = data;
      stim[u].alu_rd = 3'd1;
      stim[u].mem_rd = 3'd6;
   endtask

   // Entered just after a rising edge with the op already presented; returns just
   // after the completing edge, checking stall/bubble on every intermediate cycle.
   task automatic runOp(input int u, input int lat);
      for (int k = 0; k < lat - 1; k++) begin
         #1 checkOutput("stall_hi", 32'(obs_stall[u]), 32'd1);
         @(posedge clk);
         #1 checkOutput("bubble_valid", 32'(obs_valid[u]), 32'd0);
      end
      #1 checkOutput("stall_lo", 32'(obs_stall[u]), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 3; i++) stim[i] = '0;
      rst_n = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         checkOutput("rst_valid", 32'(obs_valid[i]), 32'd0);
         checkOutput("rst_stall", 32'(obs_stall[i]), 32'd0);
         checkOutput("rst_memout", obs_mem[i], 32'd0);
      end
      rst_n = 3'b111;

      $display("[TB] latency 2: stores, loads, misalignment, forwarding");
      applyStimulus(0, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF); runOp(0, 2);
      checkOutput("sw_valid", 32'(obs_valid[0]), 32'd1);
      checkOutput("sw_mis", 32'(obs_mis[0]), 32'd0);
      checkOutput("sw_memout", obs_mem[0], 32'd0);
      applyStimulus(0, 1, 0, 2'b00, 1, 32'h13, 32'h0); runOp(0, 2);
      checkOutput("lb_signed", obs_mem[0], 32'hFFFFFFDE);
      checkOutput("lb_memrd", 32'(obs_memrd[0]), 32'd6);
      applyStimulus(0, 1, 0, 2'b01, 0, 32'h12, 32'h0); runOp(0, 2);
      checkOutput("lhu", obs_mem[0], 32'h0000DEAD);
      applyStimulus(0, 1, 0, 2'b01, 1, 32'h12, 32'h0); runOp(0, 2);
      checkOutput("lh_signed", obs_mem[0], 32'hFFFFDEAD);
      applyStimulus(0, 1, 0, 2'b10, 0, 32'h11, 32'h0); runOp(0, 2);
      checkOutput("lw_odd_mis", 32'(obs_mis[0]), 32'd1);
      checkOutput("lw_odd_memout", obs_mem[0], 32'd0);
      checkOutput("lw_odd_valid", 32'(obs_valid[0]), 32'd1);
      applyStimulus(0, 0, 1, 2'b10, 0, 32'h11, 32'h11111111); runOp(0, 2);
      checkOutput("sw_odd_mis", 32'(obs_mis[0]), 32'd1);
      applyStimulus(0, 1, 0, 2'b11, 0, 32'h10, 32'h0); runOp(0, 2);
      checkOutput("l_sz11_mis", 32'(obs_mis[0]), 32'd1);
      checkOutput("l_sz11_memout", obs_mem[0], 32'd0);
      applyStimulus(0, 0, 1, 2'b11, 0, 32'h10, 32'h0); runOp(0, 2);
      checkOutput("s_sz11_mis", 32'(obs_mis[0]), 32'd1);
      applyStimulus(0, 1, 0, 2'b10, 0, 32'h10, 32'h0); runOp(0, 2);
      checkOutput("lw_unchanged", obs_mem[0], 32'hDEADBEEF);
      checkOutput("lw_aligned_mis", 32'(obs_mis[0]), 32'd0);

      applyStimulus(0, 0, 1, 2'b10, 0, 32'h20, 32'h0);
      stim[0].sel = 1'b1;
      stim[0].fwd = 32'h12345678;
      runOp(0, 2);
      applyStimulus(0, 1, 0, 2'b10, 0, 32'h20, 32'h0); runOp(0, 2);
      checkOutput("fwd_readback", obs_mem[0], 32'h12345678);

      applyStimulus(0, 1, 1, 2'b10, 0, 32'h30, 32'hCAFEF00D); runOp(0, 2);
      checkOutput("rdwr_memout", obs_mem[0], 32'd0);
      applyStimulus(0, 1, 0, 2'b10, 0, 32'h30, 32'h0); runOp(0, 2);
      checkOutput("rdwr_stored", obs_mem[0], 32'hCAFEF00D);

      applyStimulus(0, 0, 1, 2'b01, 0, 32'h40, 32'h55558001); runOp(0, 2);
      applyStimulus(0, 1, 0, 2'b01, 1, 32'h40, 32'h0); runOp(0, 2);
      checkOutput("sh_lh_signed", obs_mem[0], 32'hFFFF8001);
      applyStimulus(0, 1, 0, 2'b00, 0, 32'h41, 32'h0); runOp(0, 2);
      checkOutput("sh_lbu_hi", obs_mem[0], 32'h00000080);

      stim[0]         = '0;
      stim[0].valid   = 1'b1;
      stim[0].alu_rd  = 3'd5;
      stim[0].alu_out = 32'h000055AA;
      stim[0].flags   = 4'b1010;
      runOp(0, 1);
      checkOutput("alu_valid", 32'(obs_valid[0]), 32'd1);
      checkOutput("alu_out", obs_alu[0], 32'h000055AA);
      checkOutput("alu_rd", 32'(obs_alurd[0]), 32'd5);
      checkOutput("alu_flags", 32'(obs_flags[0]), 32'hA);
      checkOutput("alu_memout", obs_mem[0], 32'd0);

      applyStimulus(0, 0, 1, 2'b10, 0, 32'h10, 32'h0);
      stim[0].valid = 1'b0;
      runOp(0, 1);
      checkOutput("invalid_valid", 32'(obs_valid[0]), 32'd0);
      applyStimulus(0, 1, 0, 2'b10, 0, 32'h10, 32'h0); runOp(0, 2);
      checkOutput("invalid_nowrite", obs_mem[0], 32'hDEADBEEF);
      stim[0] = '0;

      $display("[TB] latency 4: reset aborts a stalled store");
      applyStimulus(1, 0, 1, 2'b10, 0, 32'h8, 32'h11223344); runOp(1, 4);
      checkOutput("l4_store_valid", 32'(obs_valid[1]), 32'd1);
      applyStimulus(1, 0, 1, 2'b10, 0, 32'h8, 32'h99999999);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("l4_cnt_before", 32'(gen_u[1].u_dut.cnt), 32'd2);
      checkOutput("l4_stall_before", 32'(obs_stall[1]), 32'd1);
      rst_n[1] = 1'b0;
      @(posedge clk); #1;
      checkOutput("l4_rst_valid", 32'(obs_valid[1]), 32'd0);
      checkOutput("l4_rst_cnt", 32'(gen_u[1].u_dut.cnt), 32'd0);
      stim[1]  = '0;
      rst_n[1] = 1'b1;
      #1 checkOutput("l4_rst_stall", 32'(obs_stall[1]), 32'd0);
      applyStimulus(1, 1, 0, 2'b10, 0, 32'h8, 32'h0); runOp(1, 4);
      checkOutput("l4_prior_value", obs_mem[1], 32'h11223344);
      stim[1] = '0;

      $display("[TB] latency 1: back-to-back ops and address wrap");
      stim[2]         = '0;
      stim[2].valid   = 1'b1;
      stim[2].alu_out = 32'h00000077;
      runOp(2, 1);
      checkOutput("l1_alu_valid", 32'(obs_valid[2]), 32'd1);
      checkOutput("l1_alu_out", obs_alu[2], 32'h00000077);
      applyStimulus(2, 0, 1, 2'b10, 0, 32'h00000404, 32'hA5A5A5A5); runOp(2, 1);
      checkOutput("l1_store_valid", 32'(obs_valid[2]), 32'd1);
      applyStimulus(2, 1, 0, 2'b10, 0, 32'h00000004, 32'h0); runOp(2, 1);
      checkOutput("l1_load_valid", 32'(obs_valid[2]), 32'd1);
      checkOutput("l1_wrap_load", obs_mem[2], 32'hA5A5A5A5);
      stim[2] = '0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
